// File: rtl/wb_dsp_master_arbiter.sv
// wb_dsp_master_arbiter
// Round-robin Wishbone master front-end: NUM_REQ requesters share one
// registered single-transfer Wishbone master port, with retry handling and
// per-requester completion/error pulses.
//
// Optional feature macro: WB_DSP_ARB_TIMEOUT_EN
//   Defined   -> a BUS watchdog ends a transfer with error after TIMEOUT
//                BUS cycles without any slave response.
//   Undefined -> BUS waits indefinitely; TIMEOUT has no effect.
//
// Handshake: a requester raises req_start[i] for one cycle and then holds
// its address/selection/write/data stable until req_done[i] pulses; a second
// pulse while the request is still pending is absorbed. req_error[i] pulses
// together with req_done[i] when the transfer failed, and req_data_rd is
// valid with req_done[i] for reads (held until the next read ack). On the
// Wishbone side cyc and stb are always asserted together and the transfer
// fields stay stable while cyc/stb are high and through a retry gap.
module wb_dsp_master_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int aw        = 32,
    parameter int dw        = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    // requester side
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [NUM_REQ*aw-1:0]   req_address,
    input  logic [NUM_REQ*4-1:0]    req_selection,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*dw-1:0]   req_data_wr,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_error,
    output logic [dw-1:0]           req_data_rd,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    active,
    // Wishbone master port
    output logic [aw-1:0]           wb_adr_o,
    output logic [dw-1:0]           wb_dat_o,
    output logic [3:0]              wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [dw-1:0]           wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i,
    // debug: current FSM state (0 IDLE, 1 BUS, 2 RETRY, 3 DONE)
    output logic [1:0]              o_dbg_state
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RETRY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // registered state
    state_t             r_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_grant;
    logic [IW-1:0]      r_gidx;
    logic [IW-1:0]      r_ptr;
    logic [3:0]         r_retry_cnt;
    logic               r_cyc;
    logic [aw-1:0]      r_adr;
    logic [dw-1:0]      r_dat;
    logic [3:0]         r_sel;
    logic               r_we;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_error;
    logic [dw-1:0]      r_data_rd;

    // combinational helpers
    logic               w_any;
    logic [IW-1:0]      w_sel_idx;
    int                 w_cand;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [NUM_REQ-1:0] w_clr;
    logic [aw-1:0]      w_sel_adr;
    logic [dw-1:0]      w_sel_dat;
    logic [3:0]         w_sel_sel;
    logic               w_sel_we;
    logic               w_finish;
    logic               w_fail;
    logic               w_retry;

`ifdef WB_DSP_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]     r_wdog;
`else
    logic [31:0]        w_timeout_unused;
    assign w_timeout_unused = 32'(TIMEOUT);
`endif

    // Round-robin pick: first pending bit after the last-granted index, wrapping.
    always_comb begin
        w_any     = 1'b0;
        w_sel_idx = '0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_any && r_pending[IW'(w_cand)]) begin
                w_any     = 1'b1;
                w_sel_idx = IW'(w_cand);
            end
        end
    end

    assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_sel_adr    = req_address[w_sel_idx*aw +: aw];
    assign w_sel_dat    = req_data_wr[w_sel_idx*dw +: dw];
    assign w_sel_sel    = req_selection[w_sel_idx*4 +: 4];
    assign w_sel_we     = req_write[w_sel_idx];

    // BUS outcome for this edge: ack beats err beats rty beats watchdog.
    always_comb begin
        w_finish = 1'b0;
        w_fail   = 1'b0;
        w_retry  = 1'b0;
        if (r_state == ST_BUS) begin
            if (wb_ack_i) begin
                w_finish = 1'b1;
            end else if (wb_err_i) begin
                w_finish = 1'b1;
                w_fail   = 1'b1;
            end else if (wb_rty_i) begin
                if (r_retry_cnt < 4'(MAX_RETRY)) begin
                    w_retry = 1'b1;
                end else begin
                    w_finish = 1'b1;
                    w_fail   = 1'b1;
                end
            end
`ifdef WB_DSP_ARB_TIMEOUT_EN
            else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                w_finish = 1'b1;
                w_fail   = 1'b1;
            end
`endif
        end
    end

`ifdef WB_DSP_ARB_TIMEOUT_EN
    // Watchdog: zero outside BUS, so every entry into BUS starts a fresh count.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wdog <= '0;
        end else if (r_state != ST_BUS) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`endif

    // Pending bits: the granted bit clears in DONE, but a new start in that
    // same cycle is ORed in afterwards and therefore wins.
    assign w_clr = (r_state == ST_DONE) ? r_grant : '0;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req_start;
        end
    end

    // Transfer FSM with registered bus fields, grant and completion pulses.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_ptr       <= IW'(NUM_REQ - 1);
            r_retry_cnt <= '0;
            r_cyc       <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_done      <= '0;
            r_error     <= '0;
            r_data_rd   <= '0;
        end else begin
            r_done  <= '0;
            r_error <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel_onehot;
                        r_gidx  <= w_sel_idx;
                        r_adr   <= w_sel_adr;
                        r_dat   <= w_sel_dat;
                        r_sel   <= w_sel_sel;
                        r_we    <= w_sel_we;
                        r_cyc   <= 1'b1;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (w_finish) begin
                        // bus fields return to zero so the port idles at all-zero
                        r_cyc   <= 1'b0;
                        r_adr   <= '0;
                        r_dat   <= '0;
                        r_sel   <= '0;
                        r_we    <= 1'b0;
                        r_done  <= r_grant;
                        r_error <= w_fail ? r_grant : '0;
                        if (wb_ack_i && !r_we) begin
                            r_data_rd <= wb_dat_i;
                        end
                        r_state <= ST_DONE;
                    end else if (w_retry) begin
                        r_retry_cnt <= r_retry_cnt + 4'd1;
                        r_cyc       <= 1'b0;
                        r_state     <= ST_RETRY;
                    end
                end
                ST_RETRY: begin
                    // one-cycle gap with fields held, then re-issue
                    r_cyc   <= 1'b1;
                    r_state <= ST_BUS;
                end
                ST_DONE: begin
                    r_grant     <= '0;
                    r_ptr       <= r_gidx;
                    r_retry_cnt <= '0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_done    = r_done;
    assign req_error   = r_error;
    assign req_data_rd = r_data_rd;
    assign grant       = r_grant;
    assign active      = (r_state != ST_IDLE);
    assign wb_adr_o    = r_adr;
    assign wb_dat_o    = r_dat;
    assign wb_sel_o    = r_sel;
    assign wb_we_o     = r_we;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_cti_o    = 3'b000;
    assign wb_bte_o    = 2'b00;
    assign o_dbg_state = r_state;

endmodule
